// File: rtl/pic_pkg.sv
// pic_pkg: shared constants and helpers for the PIC datapath blocks.
//   PIC_NUM_IRQ      default number of interrupt request channels
//   PIC_SYNC_STAGES  default synchroniser depth on each request line
//   ICW1_LTIM_BIT    bit position of LTIM (level/edge select) inside ICW1
//   pic_idx_w()      width of a channel index bus for a given channel count
package pic_pkg;

    localparam int PIC_NUM_IRQ     = 8;
    localparam int PIC_SYNC_STAGES = 2;
    localparam int ICW1_LTIM_BIT   = 3;

    // Index width never drops below one bit so degenerate counts still elaborate.
    function automatic int pic_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: combinational fixed-priority finder.
//   req    [NUM_IRQ]  request vector, bit 0 has the highest priority
//   idx    [IDX_W]    index of the lowest-numbered set bit, 0 when none set
//   valid             1 when any bit of req is set
module irq_priority_encoder
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = PIC_NUM_IRQ,
    parameter int IDX_W   = pic_idx_w(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Scan from the top down so the lowest set bit is written last and wins.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/param_interrupt_request_register.sv
// param_interrupt_request_register: interrupt request register (IRR) of the PIC.
// Synchronises the raw request lines, latches them in edge or level mode,
// masks them with the IMR and hands a registered pending vector plus the
// fixed-priority winner to the priority resolver. Serviced channels are
// cleared through a serviceReq/serviceAck handshake.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   irqIn          raw request lines (asynchronous to clk)
//   bitToMask      IMR, 1 = channel masked
//   levelMode      LTIM: 1 = level-triggered, 0 = edge-triggered
//   serviceReq     clear channel serviceIdx this cycle
//   serviceIdx     channel to clear (out-of-range values clear nothing)
//   readIRR        drive the raw IRR onto dataBuffer
//   risedBits      registered irr & ~bitToMask
//   anyPending     registered OR of risedBits
//   highestIdx     registered lowest set index of risedBits (0 when none)
//   serviceAck     one-cycle pulse one cycle after each serviceReq cycle
//   dataBuffer     irr when readIRR=1, otherwise high-Z
//
// Optional feature (macro IRR_OVERFLOW_EN):
//   overflowClr    clears all overflow flags on the next edge
//   overflowBits   sticky flags: an edge-mode rise hit an already-pending channel
module param_interrupt_request_register
    import pic_pkg::*;
#(
    parameter int NUM_IRQ     = PIC_NUM_IRQ,
    parameter int SYNC_STAGES = PIC_SYNC_STAGES,
    parameter int IDX_W       = pic_idx_w(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irqIn,
    input  logic [NUM_IRQ-1:0] bitToMask,
    input  logic               levelMode,
    input  logic               serviceReq,
    input  logic [IDX_W-1:0]   serviceIdx,
    input  logic               readIRR,
    output logic [NUM_IRQ-1:0] risedBits,
    output logic               anyPending,
    output logic [IDX_W-1:0]   highestIdx,
    output logic               serviceAck,
    output logic [NUM_IRQ-1:0] dataBuffer
`ifdef IRR_OVERFLOW_EN
    ,
    input  logic               overflowClr,
    output logic [NUM_IRQ-1:0] overflowBits
`endif
);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0] irr_q, irr_d;
    logic [NUM_IRQ-1:0] blocked_q, blocked_d;
    logic               level_q, level_d;
    logic [NUM_IRQ-1:0] rised_q, rised_d;
    logic               any_q, any_d;
    logic [IDX_W-1:0]   highest_q, highest_d;
    logic               ack_q, ack_d;
`ifdef IRR_OVERFLOW_EN
    logic [NUM_IRQ-1:0] ovf_q, ovf_d;
`endif

    logic [NUM_IRQ-1:0] irq_sync;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr_vec;

    // Synchroniser chain: stage 0 samples the raw lines.
    always_comb begin
        sync_d[0] = irqIn;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign irq_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        irq_prev_d = irq_sync;
        level_d    = levelMode;
        rise       = irq_sync & ~irq_prev_q;
        ack_d      = serviceReq;

        // Decode the clear; an index beyond the channel count matches nothing.
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_vec[i] = serviceReq && (int'(serviceIdx) == i);
        end

        irr_d     = irr_q;
        blocked_d = blocked_q;
        if (levelMode) begin
            if (!level_q) begin
                // First level-mode cycle after edge mode: start fresh from the lines.
                irr_d     = irq_sync;
                blocked_d = '0;
            end else begin
                // A serviced channel stays blocked until its line is seen low.
                blocked_d = (blocked_q | clr_vec) & irq_sync;
                irr_d     = irq_sync & ~blocked_d;
            end
        end else begin
            // OR-ing the rise in last lets a same-cycle set beat the clear.
            irr_d = (irr_q & ~clr_vec) | rise;
        end

        rised_d = irr_d & ~bitToMask;

`ifdef IRR_OVERFLOW_EN
        ovf_d = overflowClr ? '0 : ovf_q;
        if (!levelMode) begin
            ovf_d = ovf_d | (rise & irr_q);
        end
`endif
    end

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio (
        .req   (rised_d),
        .idx   (highest_d),
        .valid (any_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            irq_prev_q <= '0;
            irr_q      <= '0;
            blocked_q  <= '0;
            level_q    <= 1'b0;
            rised_q    <= '0;
            any_q      <= 1'b0;
            highest_q  <= '0;
            ack_q      <= 1'b0;
`ifdef IRR_OVERFLOW_EN
            ovf_q      <= '0;
`endif
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            irq_prev_q <= irq_prev_d;
            irr_q      <= irr_d;
            blocked_q  <= blocked_d;
            level_q    <= level_d;
            rised_q    <= rised_d;
            any_q      <= any_d;
            highest_q  <= highest_d;
            ack_q      <= ack_d;
`ifdef IRR_OVERFLOW_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign risedBits  = rised_q;
    assign anyPending = any_q;
    assign highestIdx = highest_q;
    assign serviceAck = ack_q;
    assign dataBuffer = readIRR ? irr_q : {NUM_IRQ{1'bz}};

`ifdef IRR_OVERFLOW_EN
    assign overflowBits = ovf_q;
`endif

endmodule

// File: tb/tb_param_interrupt_request_register.sv
// Testbench for param_interrupt_request_register (NUM_IRQ=8, SYNC_STAGES=2).
// Vectors are applied one per clock; each applied vector queues its expected
// outputs, which are popped and compared after the following rising edge.
module tb_param_interrupt_request_register;

    logic       clk;
    logic       reset;
    logic [7:0] irq_in;
    logic [7:0] mask;
    logic       level_mode;
    logic       service_req;
    logic [2:0] service_idx;
    logic       read_irr;
    logic [7:0] rised_bits;
    logic       any_pending;
    logic [2:0] highest_idx;
    logic       service_ack;
    wire  [7:0] data_buffer;
`ifdef IRR_OVERFLOW_EN
    logic       overflow_clr;
    logic [7:0] overflow_bits;
`endif

    param_interrupt_request_register #(
        .NUM_IRQ     (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irqIn      (irq_in),
        .bitToMask  (mask),
        .levelMode  (level_mode),
        .serviceReq (service_req),
        .serviceIdx (service_idx),
        .readIRR    (read_irr),
        .risedBits  (rised_bits),
        .anyPending (any_pending),
        .highestIdx (highest_idx),
        .serviceAck (service_ack),
        .dataBuffer (data_buffer)
`ifdef IRR_OVERFLOW_EN
        ,
        .overflowClr  (overflow_clr),
        .overflowBits (overflow_bits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] irq;
        logic [7:0] msk;
        logic       lvl;
        logic       sreq;
        logic [2:0] sidx;
        logic       rd;
        logic [7:0] e_rised;
        logic [2:0] e_hi;
        logic       e_ack;
        logic [7:0] e_db;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tot = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] irq, input logic [7:0] msk, input logic lvl,
                       input logic sreq, input logic [2:0] sidx, input logic rd,
                       input logic [7:0] e_rised, input logic [2:0] e_hi,
                       input logic e_ack, input logic [7:0] e_db);
        vec_t v;
        v.irq = irq; v.msk = msk; v.lvl = lvl; v.sreq = sreq; v.sidx = sidx; v.rd = rd;
        v.e_rised = e_rised; v.e_hi = e_hi; v.e_ack = e_ack; v.e_db = e_db;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        irq_in      = v.irq;
        mask        = v.msk;
        level_mode  = v.lvl;
        service_req = v.sreq;
        service_idx = v.sidx;
        read_irr    = v.rd;
    endtask

    initial begin
        vec_t v;
        vec_t e;

        //        irq    msk   lv sr idx rd  rised  hi  ack  db
        // Edge latch of IR5 (3 cycles after it is driven), held after irqIn drops.
        add(8'h20, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 0
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 1
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h20, 5, 0, 8'h00);  // 2
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h20, 5, 0, 8'h00);  // 3
        // IR2 rises while masked; unmask is visible one cycle later.
        add(8'h04, 8'h04, 0, 0, 0, 0, 8'h20, 5, 0, 8'h00);  // 4
        add(8'h00, 8'h04, 0, 0, 0, 0, 8'h20, 5, 0, 8'h00);  // 5
        add(8'h00, 8'h04, 0, 0, 0, 0, 8'h20, 5, 0, 8'h00);  // 6
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h24, 2, 0, 8'h00);  // 7
        add(8'h00, 8'h00, 0, 0, 0, 1, 8'h24, 2, 0, 8'h24);  // 8
        // Service IR2, single ack pulse.
        add(8'h00, 8'h00, 0, 1, 2, 0, 8'h20, 5, 1, 8'h00);  // 9
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h20, 5, 0, 8'h00);  // 10
        // IR2 rise lands on the same edge as its clear: set wins.
        add(8'h04, 8'h00, 0, 0, 0, 0, 8'h20, 5, 0, 8'h00);  // 11
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h20, 5, 0, 8'h00);  // 12
        add(8'h00, 8'h00, 0, 1, 2, 0, 8'h24, 2, 1, 8'h00);  // 13
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h24, 2, 0, 8'h00);  // 14
        // Clear IR5 with a rise on IR1, then a held serviceReq = three clears.
        add(8'h02, 8'h00, 0, 0, 0, 0, 8'h24, 2, 0, 8'h00);  // 15
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h24, 2, 0, 8'h00);  // 16
        add(8'h00, 8'h00, 0, 1, 5, 0, 8'h06, 1, 1, 8'h00);  // 17
        add(8'h00, 8'h00, 0, 1, 1, 0, 8'h04, 2, 1, 8'h00);  // 18
        add(8'h00, 8'h00, 0, 1, 2, 0, 8'h00, 0, 1, 8'h00);  // 19
        add(8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 8'h00);  // 20
        // Level mode on IR3: serviced channel stays clear while the line is high.
        add(8'h08, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 21
        add(8'h08, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 22
        add(8'h08, 8'h00, 1, 0, 0, 0, 8'h08, 3, 0, 8'h00);  // 23
        add(8'h08, 8'h00, 1, 1, 3, 0, 8'h00, 0, 1, 8'h00);  // 24
        add(8'h08, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 25
        add(8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 26
        add(8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 27
        add(8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 28
        add(8'h08, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 29
        add(8'h08, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 30
        add(8'h08, 8'h00, 1, 0, 0, 0, 8'h08, 3, 0, 8'h00);  // 31
        // Back to edge mode: irr is kept, falling line does not clear it.
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h08, 3, 0, 8'h00);  // 32
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h08, 3, 0, 8'h00);  // 33
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h08, 3, 0, 8'h00);  // 34
        add(8'h00, 8'h00, 0, 1, 3, 0, 8'h00, 0, 1, 8'h00);  // 35
        add(8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 36
        // All lines rise while fully masked; raw IRR still visible on the bus.
        add(8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 37
        add(8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 38
        add(8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // 39
        add(8'h00, 8'hFF, 0, 0, 0, 1, 8'h00, 0, 0, 8'hFF);  // 40
        add(8'h00, 8'h7F, 0, 0, 0, 0, 8'h80, 7, 0, 8'h00);  // 41

        // Reset with all lines high: outputs held at zero.
        reset = 1'b1;
        irq_in = 8'hFF; mask = 8'h00; level_mode = 1'b0;
        service_req = 1'b0; service_idx = 3'd0; read_irr = 1'b1;
`ifdef IRR_OVERFLOW_EN
        overflow_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rised", 32'(rised_bits), 32'h00);
        chk("rst_any", 32'(any_pending), 32'h0);
        chk("rst_hi", 32'(highest_idx), 32'h0);
        chk("rst_ack", 32'(service_ack), 32'h0);
        chk("rst_irr", 32'(data_buffer), 32'h00);
`ifdef IRR_OVERFLOW_EN
        chk("rst_ovf", 32'(overflow_bits), 32'h00);
`endif
        irq_in = 8'h00; read_irr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_rised", 32'(rised_bits), 32'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v);
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_rised", i), 32'(rised_bits), 32'(e.e_rised));
            chk($sformatf("v%0d_any", i), 32'(any_pending), 32'(e.e_rised != 8'h00));
            chk($sformatf("v%0d_hi", i), 32'(highest_idx), 32'(e.e_hi));
            chk($sformatf("v%0d_ack", i), 32'(service_ack), 32'(e.e_ack));
            if (e.rd) begin
                chk($sformatf("v%0d_db", i), 32'(data_buffer), 32'(e.e_db));
            end
        end

        // Reset asserted between a serviceReq and its ack: ack is dropped.
        irq_in = 8'h00; mask = 8'h00; service_req = 1'b1; service_idx = 3'd0; read_irr = 1'b1;
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_rised", 32'(rised_bits), 32'h00);
        chk("mid_rst_any", 32'(any_pending), 32'h0);
        chk("mid_rst_irr", 32'(data_buffer), 32'h00);
        @(posedge clk);
        #1;
        chk("mid_rst_ack", 32'(service_ack), 32'h0);
        reset = 1'b0; service_req = 1'b0; read_irr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_after_ack", 32'(service_ack), 32'h0);

`ifdef IRR_OVERFLOW_EN
        // Two rises on IR1 without service flag an overflow; overflowClr clears it.
        irq_in = 8'h02; @(posedge clk); #1;
        irq_in = 8'h00; @(posedge clk); #1;
        irq_in = 8'h02; @(posedge clk); #1;
        irq_in = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_rised", 32'(rised_bits), 32'h02);
        chk("ovf_set", 32'(overflow_bits), 32'h02);
        overflow_clr = 1'b1;
        @(posedge clk);
        #1 overflow_clr = 1'b0;
        chk("ovf_clr", 32'(overflow_bits), 32'h00);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
